// File: rtl/mat_cache_loader.sv
// Streams WIDTH-element vectors into one matrix cache slot as row or column writes; one registered write per beat (1-cycle latency).
// in_ready is high only while loading and the cache never stalls, so every accepted beat becomes a write on the next cycle.
package mat_pkg;
    typedef enum logic [1:0] {
        MAT_DATA_WRITE_DISABLE = 2'd0,
        MAT_DATA_WRITE_ROW     = 2'd1,
        MAT_DATA_WRITE_COL     = 2'd2
    } MatDataWriteOp_t;
endpackage

module mat_cache_loader
    import mat_pkg::*;
#(
    parameter int WIDTH           = 128,
    parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH),
    parameter int CACHE_SIZE      = 4,
    parameter int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [CACHE_ADDR_SIZE-1:0] cmd_addr,
    input  logic [WIDTH_ADDR_SIZE-1:0] cmd_rows,
    input  logic                       cmd_col,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  shortreal                   in_data [WIDTH],
    output MatDataWriteOp_t            write_op,
    output logic [CACHE_ADDR_SIZE-1:0] write_addr1,
    output logic [CACHE_ADDR_SIZE-1:0] write_addr2,
    output logic [WIDTH_ADDR_SIZE-1:0] write_param1,
    output logic [WIDTH_ADDR_SIZE-1:0] write_param2,
    output shortreal                   data_out [WIDTH],
    output logic                       busy,
    output logic                       done
);
    localparam int CW = WIDTH_ADDR_SIZE + 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOAD = 1'b1;

    logic [0:0]                 state;
    logic [CW-1:0]              rows_q;
    logic [CW-1:0]              idx_q;
    logic [CACHE_ADDR_SIZE-1:0] slot_q;
    logic                       col_q;
    logic [CACHE_ADDR_SIZE-1:0] waddr_q;
    logic                       beat;

    assign cmd_ready    = (state == IDLE);
    assign in_ready     = (state == LOAD);
    assign beat         = in_valid && in_ready;
    assign write_addr1  = waddr_q;
    assign write_addr2  = waddr_q;
    assign write_param2 = '0;
    assign busy         = (state == LOAD) || (write_op != MAT_DATA_WRITE_DISABLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            rows_q       <= '0;
            idx_q        <= '0;
            slot_q       <= '0;
            col_q        <= 1'b0;
            waddr_q      <= '0;
            write_op     <= MAT_DATA_WRITE_DISABLE;
            write_param1 <= '0;
            done         <= 1'b0;
            for (int i = 0; i < WIDTH; i++) data_out[i] <= 0.0;
        end else begin
            write_op <= MAT_DATA_WRITE_DISABLE;
            done     <= 1'b0;
            if (state == IDLE && cmd_valid) begin
                slot_q <= cmd_addr;
                col_q  <= cmd_col;
                // A zero row count means a full WIDTH-row load; the extra counter bit keeps it distinct.
                rows_q <= (cmd_rows == '0) ? CW'(WIDTH) : {1'b0, cmd_rows};
                idx_q  <= '0;
                state  <= LOAD;
            end
            if (beat) begin
                data_out     <= in_data;
                write_op     <= col_q ? MAT_DATA_WRITE_COL : MAT_DATA_WRITE_ROW;
                write_param1 <= idx_q[WIDTH_ADDR_SIZE-1:0];
                waddr_q      <= slot_q;
                idx_q        <= idx_q + CW'(1);
                if (idx_q == rows_q - CW'(1)) begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_mat_cache_loader.sv
module tb_mat_cache_loader;
    import mat_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic            cmd_valid = 0, cmd_col = 0, in_valid = 0;
    logic [1:0]      cmd_addr = 0;
    logic [6:0]      cmd_rows = 0;
    logic            cmd_ready, in_ready, busy, done;
    shortreal        in_data [128];
    shortreal        data_out [128];
    MatDataWriteOp_t write_op;
    logic [1:0]      write_addr1, write_addr2;
    logic [6:0]      write_param1, write_param2;

    logic            w4_cmd_valid = 0, w4_cmd_col = 0, w4_in_valid = 0;
    logic [1:0]      w4_cmd_addr = 0, w4_cmd_rows = 0;
    logic            w4_cmd_ready, w4_in_ready, w4_busy, w4_done;
    shortreal        w4_in_data [4];
    shortreal        w4_data_out [4];
    MatDataWriteOp_t w4_write_op;
    logic [1:0]      w4_write_addr1, w4_write_addr2, w4_write_param1, w4_write_param2;

    int checks = 0;
    int errors = 0;
    shortreal cache [4][128][128];

    mat_cache_loader dut (
        .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_rows(cmd_rows), .cmd_col(cmd_col), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .write_op(write_op), .write_addr1(write_addr1),
        .write_addr2(write_addr2), .write_param1(write_param1), .write_param2(write_param2),
        .data_out(data_out), .busy(busy), .done(done)
    );

    mat_cache_loader #(.WIDTH(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .cmd_valid(w4_cmd_valid), .cmd_ready(w4_cmd_ready),
        .cmd_addr(w4_cmd_addr), .cmd_rows(w4_cmd_rows), .cmd_col(w4_cmd_col), .in_valid(w4_in_valid),
        .in_ready(w4_in_ready), .in_data(w4_in_data), .write_op(w4_write_op), .write_addr1(w4_write_addr1),
        .write_addr2(w4_write_addr2), .write_param1(w4_write_param1), .write_param2(w4_write_param2),
        .data_out(w4_data_out), .busy(w4_busy), .done(w4_done)
    );

    // Behavioural cache: commits whatever write is presented during the cycle.
    always @(negedge clock) begin
        if (write_op == MAT_DATA_WRITE_ROW)
            for (int i = 0; i < 128; i++) cache[write_addr1][write_param1][i] = data_out[i];
        else if (write_op == MAT_DATA_WRITE_COL)
            for (int i = 0; i < 128; i++) cache[write_addr1][i][write_param1] = data_out[i];
    end

    initial begin
        for (int i = 0; i < 128; i++) in_data[i] = 0.0;
        for (int i = 0; i < 4; i++) w4_in_data[i] = 0.0;
    end

    task automatic run_load(input logic [1:0] slot, input logic [6:0] rows_enc, input logic col,
                            input int mode, input bit seq_data, input string name);
        int r = (rows_enc == 0) ? 128 : int'(rows_enc);
        int k = 0;
        int cyc = 0;
        bit v;
        bit bad;
        shortreal exp_d [128];
        MatDataWriteOp_t exp_op = col ? MAT_DATA_WRITE_COL : MAT_DATA_WRITE_ROW;

        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL %s idle cmd_ready got %b want 1", name, cmd_ready);
        end
        cmd_valid = 1; cmd_addr = slot; cmd_rows = rows_enc; cmd_col = col; in_valid = 0;
        @(posedge clock); #1;
        cmd_valid = 0; cmd_addr = 2'($urandom); cmd_rows = 7'($urandom); cmd_col = 1'($urandom);
        checks++;
        if (cmd_ready !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL %s load entry cmd_ready=%b in_ready=%b busy=%b want 0 1 1",
                               name, cmd_ready, in_ready, busy);
        end
        while (k < r && cyc < 2000) begin
            cyc++;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
            in_valid = v;
            for (int i = 0; i < 128; i++) begin
                in_data[i] = seq_data ? shortreal'(k * 128 + i) : shortreal'($urandom_range(0, 65535));
                exp_d[i] = in_data[i];
            end
            @(posedge clock); #1;
            checks++;
            if (v) begin
                bad = 0;
                for (int i = 0; i < 128; i++) if (data_out[i] != exp_d[i]) bad = 1;
                if (write_op !== exp_op || write_addr1 !== slot || write_addr2 !== slot ||
                    write_param1 !== 7'(k) || write_param2 !== 7'd0 || done !== (k == r - 1) || bad) begin
                    errors++;
                    $display("FAIL %s write %0d op=%0d addr=%0d/%0d param=%0d p2=%0d done=%b data_bad=%b want op=%0d addr=%0d param=%0d done=%b",
                             name, k, write_op, write_addr1, write_addr2, write_param1, write_param2, done, bad,
                             exp_op, slot, k, (k == r - 1));
                end
                k++;
            end else begin
                if (write_op !== MAT_DATA_WRITE_DISABLE || done !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s gap op=%0d done=%b busy=%b want DISABLE 0 1", name, write_op, done, busy);
                end
            end
        end
        in_valid = 0;
        checks++;
        if (k < r) begin
            errors++; $display("FAIL %s timeout beats got %0d want %0d", name, k, r);
        end
        @(posedge clock); #1;
        checks++;
        if (write_op !== MAT_DATA_WRITE_DISABLE || busy !== 1'b0 || cmd_ready !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL %s tail op=%0d busy=%b cmd_ready=%b in_ready=%b want DISABLE 0 1 0",
                               name, write_op, busy, cmd_ready, in_ready);
        end
    endtask

    task automatic test_reset();
        bit bad = 0;
        reset_n = 0;
        repeat (2) @(posedge clock); #1;
        for (int i = 0; i < 128; i++) if (data_out[i] != 0.0) bad = 1;
        checks++;
        if (cmd_ready !== 1 || in_ready !== 0 || busy !== 0 || done !== 0 || write_op !== MAT_DATA_WRITE_DISABLE ||
            write_addr1 !== 0 || write_addr2 !== 0 || write_param1 !== 0 || write_param2 !== 0 || bad) begin
            errors++; $display("FAIL reset_state cmd_ready=%b in_ready=%b busy=%b done=%b op=%0d addr=%0d param=%0d data_bad=%b",
                               cmd_ready, in_ready, busy, done, write_op, write_addr1, write_param1, bad);
        end
        reset_n = 1;
        @(posedge clock); #1;
        cmd_valid = 1; cmd_addr = 1; cmd_rows = 5; cmd_col = 0;
        @(posedge clock); #1;
        cmd_valid = 0; in_valid = 1;
        for (int i = 0; i < 128; i++) in_data[i] = shortreal'(i + 1);
        @(posedge clock); #1;
        in_valid = 0;
        checks++;
        if (write_op !== MAT_DATA_WRITE_ROW || busy !== 1) begin
            errors++; $display("FAIL reset_pre op=%0d busy=%b want ROW 1", write_op, busy);
        end
        #2 reset_n = 0;
        #1;
        checks++;
        if (write_op !== MAT_DATA_WRITE_DISABLE || cmd_ready !== 1 || busy !== 0 || done !== 0 || in_ready !== 0) begin
            errors++; $display("FAIL reset_async op=%0d cmd_ready=%b busy=%b done=%b in_ready=%b want DISABLE 1 0 0 0",
                               write_op, cmd_ready, busy, done, in_ready);
        end
        @(posedge clock); #1;
        reset_n = 1;
        @(posedge clock); #1;
    endtask

    task automatic test_full_row_load();
        bit bad = 0;
        int rr;
        run_load(2'd2, 7'd0, 1'b0, 0, 1'b1, "full_row");
        for (int t = 0; t < 4; t++) begin
            rr = (t == 3) ? 127 : $urandom_range(0, 126);
            for (int i = 0; i < 128; i++) if (cache[2][rr][i] != shortreal'(rr * 128 + i)) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL full_row_cache readback got corrupted rows want r*128+i");
        end
    endtask

    task automatic test_col_gaps();
        run_load(2'd1, 7'd3, 1'b1, 1, 1'b0, "col_gaps");
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1; cmd_addr = 0; cmd_rows = 1; cmd_col = 0;
        @(posedge clock); #1;
        cmd_addr = 3; cmd_rows = 2; cmd_col = 0; in_valid = 1;
        for (int i = 0; i < 128; i++) in_data[i] = shortreal'(1000 + i);
        @(posedge clock); #1;
        checks++;
        if (done !== 1 || write_op !== MAT_DATA_WRITE_ROW || write_addr1 !== 0 || write_param1 !== 0 || cmd_ready !== 1) begin
            errors++; $display("FAIL b2b_a_done done=%b op=%0d addr=%0d param=%0d cmd_ready=%b want 1 ROW 0 0 1",
                               done, write_op, write_addr1, write_param1, cmd_ready);
        end
        @(posedge clock); #1;
        cmd_valid = 0;
        checks++;
        if (cmd_ready !== 0 || in_ready !== 1 || write_op !== MAT_DATA_WRITE_DISABLE) begin
            errors++; $display("FAIL b2b_b_accept cmd_ready=%b in_ready=%b op=%0d want 0 1 DISABLE",
                               cmd_ready, in_ready, write_op);
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clock); #1;
            checks++;
            if (write_op !== MAT_DATA_WRITE_ROW || write_addr1 !== 3 || write_param1 !== 7'(k) || done !== (k == 1)) begin
                errors++; $display("FAIL b2b_b_write%0d op=%0d addr=%0d param=%0d done=%b want ROW 3 %0d %b",
                                   k, write_op, write_addr1, write_param1, done, k, (k == 1));
            end
        end
        in_valid = 0;
        @(posedge clock); #1;
    endtask

    task automatic test_ignored_beats();
        shortreal keep [128];
        bit bad;
        for (int i = 0; i < 128; i++) keep[i] = data_out[i];
        in_valid = 1;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < 128; i++) in_data[i] = shortreal'($urandom_range(70000, 90000));
            @(posedge clock); #1;
            bad = 0;
            for (int i = 0; i < 128; i++) if (data_out[i] != keep[i]) bad = 1;
            checks++;
            if (in_ready !== 0 || write_op !== MAT_DATA_WRITE_DISABLE || bad) begin
                errors++; $display("FAIL ignored_beat%0d in_ready=%b op=%0d data_changed=%b want 0 DISABLE 0",
                                   c, in_ready, write_op, bad);
            end
        end
        in_valid = 0;
    endtask

    task automatic test_random_loads();
        for (int t = 0; t < 5; t++)
            run_load(2'($urandom), 7'($urandom_range(1, 12)), 1'($urandom), 2, 1'b0, $sformatf("random%0d", t));
    endtask

    task automatic test_width_wrap();
        w4_cmd_valid = 1; w4_cmd_addr = 3; w4_cmd_rows = 0; w4_cmd_col = 0;
        @(posedge clock); #1;
        w4_cmd_valid = 0; w4_in_valid = 1;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) w4_in_data[i] = shortreal'(k * 4 + i);
            @(posedge clock); #1;
            checks++;
            if (w4_write_op !== MAT_DATA_WRITE_ROW || w4_write_param1 !== 2'(k) || w4_write_addr1 !== 3 ||
                w4_done !== (k == 3) || w4_data_out[3] != shortreal'(k * 4 + 3)) begin
                errors++; $display("FAIL wrap_write%0d op=%0d param=%0d addr=%0d done=%b want ROW %0d 3 %b",
                                   k, w4_write_op, w4_write_param1, w4_write_addr1, w4_done, k, (k == 3));
            end
        end
        checks++;
        if (w4_in_ready !== 0 || w4_cmd_ready !== 1) begin
            errors++; $display("FAIL wrap_idle in_ready=%b cmd_ready=%b want 0 1", w4_in_ready, w4_cmd_ready);
        end
        for (int c = 0; c < 2; c++) begin
            @(posedge clock); #1;
            checks++;
            if (w4_write_op !== MAT_DATA_WRITE_DISABLE || w4_busy !== 0) begin
                errors++; $display("FAIL wrap_extra%0d op=%0d busy=%b want DISABLE 0", c, w4_write_op, w4_busy);
            end
        end
        w4_in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_full_row_load();
        test_col_gaps();
        test_back_to_back();
        test_ignored_beats();
        test_random_loads();
        test_width_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
